// File: rtl/pll_camera_lock_supervisor_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_camera_lock_supervisor_if
// Description : Signal bundle between the camera PLL lock supervisor and its
//               environment (PLL wrapper, camera reset fan-out, CSR status).
//               slave  : the supervisor (consumes pll_locked/retry_req,
//                        drives resets and status).
//               master : the environment (drives pll_locked/retry_req,
//                        observes resets and status).
//   pll_locked      PLL locked output, asynchronous to refclk
//   retry_req       single-cycle pulse restarting bring-up from FAIL
//   pll_rst         PLL reset, active high
//   cam_rst         camera-domain reset, active high
//   pll_ready       high only while the camera clock is usable (RUN)
//   pll_fail        high only after bring-up has given up (FAIL)
//   retry_count     lock timeouts in the current bring-up sequence
//   lock_loss_count lock losses seen while running, saturating
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_camera_lock_supervisor_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             retry_req;
    logic             pll_rst;
    logic             cam_rst;
    logic             pll_ready;
    logic             pll_fail;
    logic [2:0]       retry_count;
    logic [CNT_W-1:0] lock_loss_count;

    modport master (
        output pll_locked,
        output retry_req,
        input  pll_rst,
        input  cam_rst,
        input  pll_ready,
        input  pll_fail,
        input  retry_count,
        input  lock_loss_count
    );

    modport slave (
        input  pll_locked,
        input  retry_req,
        output pll_rst,
        output cam_rst,
        output pll_ready,
        output pll_fail,
        output retry_count,
        output lock_loss_count
    );
endinterface
`default_nettype wire

// File: rtl/pll_camera_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_camera_lock_supervisor
// Description : Brings up the 24 MHz camera PLL from the 50 MHz reference
//               domain. Pulses the PLL reset, waits (bounded) for a
//               synchronized lock, demands an unbroken run of locked cycles
//               before releasing the camera reset, re-runs bring-up on lock
//               loss and parks the PLL in reset after too many timeouts.
// Ports       : refclk - 50 MHz reference clock (only clock)
//               rst    - asynchronous active-high reset
//               bus    - pll_camera_lock_supervisor_if.slave (PLL lock in,
//                        retry request in, resets and status out)
// Revision    : 1.0 - initial release
// ============================================================================
module pll_camera_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_W               = 8
) (
    input  wire logic                   refclk,
    input  wire logic                   rst,
    pll_camera_lock_supervisor_if.slave bus
);

    // Two flops is the floor for a metastability-safe synchronizer.
    localparam int c_SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // One timer serves both the reset pulse and the lock wait, so it is
    // sized for whichever of the two is longer.
    localparam int c_TMR_MAX = (LOCK_TIMEOUT_CYCLES > RST_PULSE_CYCLES) ?
                               LOCK_TIMEOUT_CYCLES : RST_PULSE_CYCLES;
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
    localparam int c_STB_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [c_TMR_W-1:0] c_RST_LAST    = c_TMR_W'(RST_PULSE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMO_LAST    = c_TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_STB_W-1:0] c_STB_LAST    = c_STB_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]         c_RETRY_LIMIT = 3'(MAX_RETRIES);
    localparam logic [CNT_W-1:0]   c_LLC_MAX     = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [c_SYNC_N-1:0]  r_sync;
    logic                 w_locked_s;
    logic [c_TMR_W-1:0]   r_tmr;
    logic [c_TMR_W-1:0]   w_tmr_nx;
    logic [c_STB_W-1:0]   r_stb;
    logic [c_STB_W-1:0]   w_stb_nx;
    logic [2:0]           r_retry;
    logic [2:0]           w_retry_nx;
    logic [2:0]           w_retry_inc;
    logic [CNT_W-1:0]     r_llc;
    logic [CNT_W-1:0]     w_llc_nx;
    logic                 r_pll_rst;
    logic                 r_cam_rst;
    logic                 r_pll_ready;
    logic                 r_pll_fail;

    // ------------------------------------------------------------------
    // pll_locked synchronizer; only the last stage is used below.
    // ------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_SYNC_N-2:0], bus.pll_locked};
        end
    end

    assign w_locked_s  = r_sync[c_SYNC_N-1];
    assign w_retry_inc = r_retry + 3'd1;

    // ------------------------------------------------------------------
    // State and counter registers. Outputs are decoded from the next
    // state so they change on the same edge as the transition.
    // ------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RESET_PLL;
            r_tmr       <= '0;
            r_stb       <= '0;
            r_retry     <= '0;
            r_llc       <= '0;
            r_pll_rst   <= 1'b1;
            r_cam_rst   <= 1'b1;
            r_pll_ready <= 1'b0;
            r_pll_fail  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_tmr       <= w_tmr_nx;
            r_stb       <= w_stb_nx;
            r_retry     <= w_retry_nx;
            r_llc       <= w_llc_nx;
            r_pll_rst   <= (w_state_nx == S_RESET_PLL) || (w_state_nx == S_FAIL);
            r_cam_rst   <= (w_state_nx != S_RUN);
            r_pll_ready <= (w_state_nx == S_RUN);
            r_pll_fail  <= (w_state_nx == S_FAIL);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_tmr_nx   = r_tmr;
        w_stb_nx   = r_stb;
        w_retry_nx = r_retry;
        w_llc_nx   = r_llc;

        case (r_state)
            S_RESET_PLL: begin
                if (r_tmr == c_RST_LAST) begin
                    w_state_nx = S_WAIT_LOCK;
                    w_tmr_nx   = '0;
                end else begin
                    w_tmr_nx   = r_tmr + 1'b1;
                end
            end

            S_WAIT_LOCK: begin
                // Lock is checked first so it wins over a coincident timeout.
                if (w_locked_s) begin
                    w_state_nx = S_STABLE;
                    w_stb_nx   = '0;
                end else if (r_tmr == c_TMO_LAST) begin
                    w_retry_nx = w_retry_inc;
                    w_tmr_nx   = '0;
                    w_state_nx = (w_retry_inc == c_RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
                end else begin
                    w_tmr_nx   = r_tmr + 1'b1;
                end
            end

            S_STABLE: begin
                // The lock-wait timer is frozen here and resumes on a drop,
                // so chatter cannot extend the total wait indefinitely.
                if (!w_locked_s) begin
                    w_state_nx = S_WAIT_LOCK;
                end else if (r_stb == c_STB_LAST) begin
                    w_state_nx = S_RUN;
                    w_retry_nx = '0;
                end else begin
                    w_stb_nx   = r_stb + 1'b1;
                end
            end

            S_RUN: begin
                if (!w_locked_s) begin
                    w_state_nx = S_RESET_PLL;
                    w_tmr_nx   = '0;
                    if (r_llc != c_LLC_MAX) begin
                        w_llc_nx = r_llc + 1'b1;
                    end
                end
            end

            S_FAIL: begin
                if (bus.retry_req) begin
                    w_state_nx = S_RESET_PLL;
                    w_tmr_nx   = '0;
                    w_retry_nx = '0;
                end
            end

            default: begin
                w_state_nx = S_RESET_PLL;
                w_tmr_nx   = '0;
            end
        endcase
    end

    assign bus.pll_rst         = r_pll_rst;
    assign bus.cam_rst         = r_cam_rst;
    assign bus.pll_ready       = r_pll_ready;
    assign bus.pll_fail        = r_pll_fail;
    assign bus.retry_count     = r_retry;
    assign bus.lock_loss_count = r_llc;

endmodule
`default_nettype wire

// File: doc/pll_camera_lock_supervisor.md
Name: pll_camera_lock_supervisor

Overview:
- Supervises the 24 MHz camera-clock PLL from the 50 MHz reference domain.
- Drives the PLL reset, qualifies the PLL `locked` output, and releases the camera-domain reset only after lock has stayed stable.
- Detects lock loss, times out failed lock attempts with bounded retries, and reports status to the HPS/CSR side.
- Sits between the camera PLL wrapper and the camera capture/SCCB logic.

Parameters:
- SYNC_STAGES, 2, flops in the pll_locked synchronizer (minimum 2).
- RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt.
- LOCK_TIMEOUT_CYCLES, 50000, refclk cycles allowed for lock after pll_rst falls (1 ms).
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before camera reset release.
- MAX_RETRIES, 4, lock timeouts tolerated before entering FAIL.
- CNT_W, 8, width of lock_loss_count.

Ports:
- refclk  in  1  50 MHz reference clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- retry_req  in  1  single-cycle pulse that restarts bring-up from FAIL.
- pll_rst  out  1  reset to the PLL, active high.
- cam_rst  out  1  camera-domain reset, active high.
- pll_ready  out  1  high only in RUN.
- pll_fail  out  1  high only in FAIL.
- retry_count  out  3  timeouts in the current bring-up sequence.
- lock_loss_count  out  CNT_W  lock losses seen in RUN; saturating.

Behaviour:
- Reset: one clock, refclk. rst is asynchronous and active-high. While rst=1:
  - state=RESET_PLL, all counters 0, synchronizer flops 0.
  - pll_rst=1, cam_rst=1, pll_ready=0, pll_fail=0, retry_count=0, lock_loss_count=0.
- Outputs: all registered, decoded from next-state. An output change appears after the edge on which the transition occurs.
- locked_s: pll_locked passed through SYNC_STAGES flops. Input-to-locked_s latency is SYNC_STAGES edges. Only locked_s is used internally.
- RESET_PLL: pll_rst=1, cam_rst=1. Counter runs 0..RST_PULSE_CYCLES-1, then go to WAIT_LOCK with timer cleared.
- WAIT_LOCK: pll_rst=0, cam_rst=1. Timer counts each cycle.
  - locked_s=1 → STABLE, stable counter cleared.
  - Timer reaches LOCK_TIMEOUT_CYCLES-1 with locked_s=0 → retry_count+1. If the new value equals MAX_RETRIES → FAIL, otherwise → RESET_PLL.
  - If locked_s and timeout occur in the same cycle, lock wins.
- STABLE: pll_rst=0, cam_rst=1.
  - Counter increments while locked_s=1.
  - locked_s=0 → back to WAIT_LOCK. The timer is not cleared, so total wait stays bounded.
  - Counter reaches STABLE_CYCLES-1 with locked_s=1 → RUN, and retry_count clears to 0.
- RUN: pll_rst=0, cam_rst=0, pll_ready=1.
  - locked_s=0 → RESET_PLL. cam_rst re-asserts on the same edge, i.e. within SYNC_STAGES+1 cycles of lock loss.
  - On that transition lock_loss_count increments, saturating at 2^CNT_W-1.
- FAIL: pll_rst=1 (PLL parked in reset), cam_rst=1, pll_fail=1. State is held.
  - retry_req=1 → RESET_PLL, with retry_count cleared. pll_fail drops on that edge.
  - retry_req is ignored in every other state.
- pll_locked glitches shorter than one refclk period may be missed. Glitches that reach locked_s are handled as described above.
- Reset mid-operation: returns immediately to the reset values and restarts at RESET_PLL. lock_loss_count is cleared.
- Arithmetic: counters are sized to their maximum parameter value. No wrap-around is permitted on the timer or stable counter.

Test Plan:
- Clean bring-up: use defaults, release rst at edge 0, assert pll_locked at edge 100 → pll_rst high for exactly edges 1..16; cam_rst first low after edge 100+2+1024=1126; pll_ready=1 and retry_count=0 at the same time.
- Lock chatter: pll_locked drops for 5 cycles 500 cycles into STABLE, then stays high → no camera release until 1024 consecutive locked_s cycles after recovery; retry_count=0.
- Timeout/retry: set LOCK_TIMEOUT_CYCLES=100 and never assert pll_locked → 4 reset pulses of 16 cycles each; retry_count steps 1,2,3; FAIL reached with pll_fail=1, pll_rst=1, cam_rst=1.
- FAIL recovery: in FAIL, pulse retry_req, then assert pll_locked 50 cycles later → pll_fail=0 next edge, retry_count=0, RUN reached normally.
- Lock loss in RUN: drop pll_locked for 1 µs, three separate times → cam_rst=1 within 3 cycles each time; lock_loss_count=3; each time it returns to RUN after re-lock. With CNT_W=2, five losses → count saturates at 3.
- Async reset mid-STABLE: assert rst between edges → all outputs take their reset values without waiting for a clock edge, and bring-up restarts after release.
